// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = $clog2(MD_ITER);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    // Selects which radix-2 iteration the step datapath performs.
    typedef enum logic {
        STEP_MUL,
        STEP_DIV
    } step_mode_t;

    // Ops that run through the iterative datapath and raise BUSY.
    function automatic logic op_is_arith(input md_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> muldiv unit bus: op request, operands, cancel, and HI/LO/BUSY back.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             START;
    md_op_t           OP;
    logic [WIDTH-1:0] SRC_A;
    logic [WIDTH-1:0] SRC_B;
    logic             CANCEL;
    logic             BUSY;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output START, OP, SRC_A, SRC_B, CANCEL, input BUSY, HI, LO);
    modport slave  (input START, OP, SRC_A, SRC_B, CANCEL, output BUSY, HI, LO);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  step_mode_t     mode,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] acc_next
);
    logic [W:0]   sum;
    logic [W:0]   top;
    logic [W-1:0] diff;

    // Multiply keeps the multiplier in the low half and shifts right; divide
    // keeps remainder:quotient and shifts left, one bit per call.
    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
        top      = acc[2*W-1:W-1];
        diff     = top[W-1:0] - operand;
        acc_next = acc;
        if (mode == STEP_MUL) begin
            acc_next = {sum, acc[W-1:1]};
        end else if (top >= {1'b0, operand}) begin
            // remainder < divisor, so the low W bits of the difference are exact
            acc_next = {diff, acc[W-2:0], 1'b1};
        end else begin
            acc_next = {top[W-1:0], acc[W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     CLK,
    input  logic     RESET,
    muldiv_if.slave  bus
);
    localparam logic [MD_CNT_W-1:0] LAST = MD_CNT_W'(MD_ITER - 1);

    state_t               state, state_next;
    logic [MD_CNT_W-1:0]  counter;
    logic [2*WIDTH-1:0]   acc, acc_next;
    logic [WIDTH-1:0]     operand;
    step_mode_t           mode;
    logic                 sign_a, sign_b;
    logic                 busy_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic                 accept, do_step, commit;
    logic                 is_arith, is_signed, is_mul;
    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem, res_hi, res_lo;

    muldiv_step #(.W(WIDTH)) u_step (
        .mode     (mode),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // Classify the requested op and form operand magnitudes for the latch.
    always_comb begin
        is_arith  = op_is_arith(bus.OP);
        is_signed = (bus.OP == OP_MULT) || (bus.OP == OP_DIV);
        is_mul    = (bus.OP == OP_MULT) || (bus.OP == OP_MULTU);
        neg_a     = is_signed & bus.SRC_A[WIDTH-1];
        neg_b     = is_signed & bus.SRC_B[WIDTH-1];
        mag_a     = neg_a ? -bus.SRC_A : bus.SRC_A;
        mag_b     = neg_b ? -bus.SRC_B : bus.SRC_B;
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: CANCEL from RUN or FIX always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_arith) state_next = RUN;
            RUN:     if (bus.CANCEL) state_next = IDLE;
                     else if (counter == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: request acceptance, iteration enable and result commit.
    always_comb begin
        accept  = (state == IDLE) && bus.START && !bus.CANCEL;
        do_step = (state == RUN) && !bus.CANCEL;
        commit  = (state == FIX) && !bus.CANCEL;
    end

    // Sign correction. A zero divisor leaves the dividend magnitude in the
    // remainder half, so re-applying the dividend sign recovers the raw SRC_A.
    always_comb begin
        prod   = (sign_a ^ sign_b) ? -acc : acc;
        quot   = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi = rem;
        res_lo = quot;
        if (mode == STEP_MUL) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (operand == '0) begin
            res_lo = '1;
        end
    end

    // Datapath: operand latch, iteration, HI/LO writes and registered BUSY.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc     <= '0;
            operand <= '0;
            counter <= '0;
            mode    <= STEP_MUL;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            busy_q <= (state_next != IDLE);
            if (accept && is_arith) begin
                // multiply: multiplier rides in the low half; divide: dividend does
                acc     <= {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
                operand <= is_mul ? mag_a : mag_b;
                mode    <= is_mul ? STEP_MUL : STEP_DIV;
                sign_a  <= neg_a;
                sign_b  <= neg_b;
                counter <= '0;
            end else if (do_step) begin
                acc     <= acc_next;
                counter <= counter + MD_CNT_W'(1);
            end
            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
            if (accept && bus.OP == OP_MTHI) hi_q <= bus.SRC_A;
            if (accept && bus.OP == OP_MTLO) lo_q <= bus.SRC_A;
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus cancel/inject/reset sequences.
module tb_muldiv_unit
    import muldiv_pkg::*;
;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op for one cycle, then count BUSY cycles. Optionally inject a
    // stray START (MULTU 2*3) or pulse CANCEL at a given BUSY cycle number.
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input int cancel_at,
                          output int busy_n, output bit held);
        logic [31:0] hi0, lo0;
        int n;
        hi0 = bus.HI;
        lo0 = bus.LO;
        held = 1'b1;
        @(negedge clk);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.SRC_A = a;
        bus.SRC_B = b;
        @(negedge clk);
        bus.START = 1'b0;
        bus.OP    = OP_NONE;
        n = 0;
        while (bus.BUSY && n < 100) begin
            n++;
            if (bus.HI !== hi0 || bus.LO !== lo0) held = 1'b0;
            bus.START  = (n == inj_at);
            bus.CANCEL = (n == cancel_at);
            if (n == inj_at) begin
                bus.OP    = OP_MULTU;
                bus.SRC_A = 32'd2;
                bus.SRC_B = 32'd3;
            end
            @(negedge clk);
            bus.START  = 1'b0;
            bus.CANCEL = 1'b0;
            bus.OP     = OP_NONE;
        end
        busy_n = n;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  bn;
        bit  held;
        rst        = 1'b1;
        bus.START  = 1'b0;
        bus.OP     = OP_NONE;
        bus.SRC_A  = '0;
        bus.SRC_B  = '0;
        bus.CANCEL = 1'b0;
        checks     = 0;
        errors     = 0;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
        vecs[1]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
        vecs[5]  = '{OP_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 33};
        vecs[7]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'd1,         32'hFFFF_FFFE, 33};
        vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        33};
        vecs[9]  = '{OP_MULT,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 33};
        vecs[10] = '{OP_NONE,  32'h5555_5555, 32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFD6, 0};
        vecs[11] = '{OP_RSVD,  32'h5555_5555, 32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFD6, 0};
        vecs[12] = '{OP_MTHI,  32'h1357_9BDF, 32'd0,        32'h1357_9BDF, 32'hFFFF_FFD6, 0};
        vecs[13] = '{OP_MTLO,  32'h2468_ACE0, 32'd0,        32'h1357_9BDF, 32'h2468_ACE0, 0};
        vecs[14] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 33};

        // reset state
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.BUSY), 32'd0);
        check("reset hi", bus.HI, 32'd0);
        check("reset lo", bus.LO, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, bn, held);
            check($sformatf("vec%0d busy cycles", i), 32'(bn), 32'(vecs[i].busy));
            check($sformatf("vec%0d hi", i), bus.HI, vecs[i].hi);
            check($sformatf("vec%0d lo", i), bus.LO, vecs[i].lo);
            if (vecs[i].busy > 0)
                check($sformatf("vec%0d hilo held in run", i), 32'(held), 32'd1);
        end

        // back-to-back MTHI / MTLO
        @(negedge clk);
        bus.START = 1'b1; bus.OP = OP_MTHI; bus.SRC_A = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi hi", bus.HI, 32'hDEAD_BEEF);
        check("mthi busy", 32'(bus.BUSY), 32'd0);
        bus.OP = OP_MTLO; bus.SRC_A = 32'h0BAD_F00D;
        @(negedge clk);
        bus.START = 1'b0; bus.OP = OP_NONE;
        check("mtlo lo", bus.LO, 32'h0BAD_F00D);
        check("mtlo hi kept", bus.HI, 32'hDEAD_BEEF);
        check("mtlo busy", 32'(bus.BUSY), 32'd0);

        // stray START during RUN is ignored
        run_op(OP_DIVU, 32'd100, 32'd7, 5, -1, bn, held);
        check("inject busy cycles", 32'(bn), 32'd33);
        check("inject hi", bus.HI, 32'd2);
        check("inject lo", bus.LO, 32'd14);

        // CANCEL at RUN cycle 10
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1, 10, bn, held);
        check("cancel busy cycles", 32'(bn), 32'd10);
        check("cancel hi kept", bus.HI, 32'd2);
        check("cancel lo kept", bus.LO, 32'd14);
        repeat (3) @(negedge clk);
        check("cancel stays idle", 32'(bus.BUSY), 32'd0);

        // START together with CANCEL is dropped (arith and MTHI)
        bus.START = 1'b1; bus.CANCEL = 1'b1; bus.OP = OP_MULT;
        bus.SRC_A = 32'd3; bus.SRC_B = 32'd3;
        @(negedge clk);
        bus.OP = OP_MTHI; bus.SRC_A = 32'hAAAA_5555;
        @(negedge clk);
        bus.START = 1'b0; bus.CANCEL = 1'b0; bus.OP = OP_NONE;
        check("start+cancel busy", 32'(bus.BUSY), 32'd0);
        repeat (2) @(negedge clk);
        check("start+cancel busy later", 32'(bus.BUSY), 32'd0);
        check("start+cancel hi", bus.HI, 32'd2);
        check("start+cancel lo", bus.LO, 32'd14);

        // fresh op after cancel still runs full length
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, bn, held);
        check("post-cancel busy", 32'(bn), 32'd33);
        check("post-cancel hi", bus.HI, 32'hFFFF_FFFF);
        check("post-cancel lo", bus.LO, 32'hFFFF_FFFD);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        bus.START = 1'b1; bus.OP = OP_MULTU; bus.SRC_A = 32'hFFFF_FFFF; bus.SRC_B = 32'd2;
        @(negedge clk);
        bus.START = 1'b0; bus.OP = OP_NONE;
        repeat (8) @(negedge clk);
        check("mid-run busy", 32'(bus.BUSY), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset busy", 32'(bus.BUSY), 32'd0);
        check("async reset hi", bus.HI, 32'd0);
        check("async reset lo", bus.LO, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset busy", 32'(bus.BUSY), 32'd0);
        run_op(OP_MULT, 32'd7, 32'd6, -1, -1, bn, held);
        check("post-reset busy cycles", 32'(bn), 32'd33);
        check("post-reset hi", bus.HI, 32'd0);
        check("post-reset lo", bus.LO, 32'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
